// File: rtl/mda_char_serializer.sv
// Text-mode dot serializer: captures a VRAM cell at dot 0, addresses the font ROM, and shifts the glyph row out one dot per pix_ce.
// Latency: a cell captured at dot 0 of cell k is on pix_out and the side-band outputs from dot 0 of cell k+1 (DOTS pix_ce later).
// Backpressure: none; all state advances only on pix_ce, and every output holds while pix_ce is low.
module mda_char_serializer #(
    parameter int DOTS     = 9,
    parameter bit LINE_GFX = 1'b1,
    parameter int ROW_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pix_ce,
    input  logic                    line_start,
    input  logic [7:0]              char_byte,
    input  logic [7:0]              att_in,
    input  logic [4:0]              row_in,
    input  logic                    cursor_in,
    input  logic                    de_in,
    output logic [8+ROW_BITS-1:0]   rom_addr,
    input  logic [7:0]              rom_data,
    output logic                    cell_start,
    output logic                    pix_out,
    output logic [7:0]              att_out,
    output logic [4:0]              row_out,
    output logic                    cursor_out,
    output logic                    de_out
);

    localparam logic [3:0] LAST_DOT  = 4'(DOTS - 1);
    localparam logic [3:0] NINTH_DOT = 4'd8;
    localparam bit         GFX_EN    = LINE_GFX && (DOTS == 9);

    logic [3:0]            dot_q, dot_d;
    logic                  gfx1_q, gfx1_d;
    logic [7:0]            att1_q, att1_d;
    logic [4:0]            row1_q, row1_d;
    logic                  cur1_q, cur1_d;
    logic                  de1_q, de1_d;
    logic [8+ROW_BITS-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]            shift_q, shift_d;
    logic                  ninth_q, ninth_d;
    logic                  pix_q, pix_d;
    logic [7:0]            att_q, att_d;
    logic [4:0]            row_q, row_d;
    logic                  cur_q, cur_d;
    logic                  de_q, de_d;
    logic                  dot0;
    logic                  load;

    always_comb begin
        // line_start overrides the count: this ce becomes dot 0 of a fresh cell
        dot0 = line_start || (dot_q == 4'd0);
        load = pix_ce && dot0;

        dot_d      = dot_q;
        gfx1_d     = gfx1_q;
        att1_d     = att1_q;
        row1_d     = row1_q;
        cur1_d     = cur1_q;
        de1_d      = de1_q;
        rom_addr_d = rom_addr_q;
        shift_d    = shift_q;
        ninth_d    = ninth_q;
        pix_d      = pix_q;
        att_d      = att_q;
        row_d      = row_q;
        cur_d      = cur_q;
        de_d       = de_q;

        if (pix_ce) begin
            if (dot0) begin
                dot_d      = 4'd1;
                gfx1_d     = GFX_EN && (char_byte[7:5] == 3'b110);
                att1_d     = att_in;
                row1_d     = row_in;
                cur1_d     = cursor_in;
                de1_d      = de_in;
                rom_addr_d = {char_byte, row_in[ROW_BITS-1:0]};
                // rom_data still holds the glyph of the cell captured one cell earlier
                pix_d      = rom_data[7];
                shift_d    = {rom_data[6:0], 1'b0};
                ninth_d    = gfx1_q && rom_data[0];
                att_d      = att1_q;
                row_d      = row1_q;
                cur_d      = cur1_q;
                de_d       = de1_q;
            end else begin
                dot_d = (dot_q == LAST_DOT) ? 4'd0 : 4'(dot_q + 4'd1);
                if (dot_q == NINTH_DOT) begin
                    pix_d = ninth_q;
                end else begin
                    pix_d   = shift_q[7];
                    shift_d = {shift_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot_q      <= '0;
            gfx1_q     <= 1'b0;
            att1_q     <= '0;
            row1_q     <= '0;
            cur1_q     <= 1'b0;
            de1_q      <= 1'b0;
            rom_addr_q <= '0;
            shift_q    <= '0;
            ninth_q    <= 1'b0;
            pix_q      <= 1'b0;
            att_q      <= '0;
            row_q      <= '0;
            cur_q      <= 1'b0;
            de_q       <= 1'b0;
        end else begin
            dot_q      <= dot_d;
            gfx1_q     <= gfx1_d;
            att1_q     <= att1_d;
            row1_q     <= row1_d;
            cur1_q     <= cur1_d;
            de1_q      <= de1_d;
            rom_addr_q <= rom_addr_d;
            shift_q    <= shift_d;
            ninth_q    <= ninth_d;
            pix_q      <= pix_d;
            att_q      <= att_d;
            row_q      <= row_d;
            cur_q      <= cur_d;
            de_q       <= de_d;
        end
    end

    assign cell_start = load;
    assign rom_addr   = rom_addr_q;
    assign pix_out    = pix_q;
    assign att_out    = att_q;
    assign row_out    = row_q;
    assign cursor_out = cur_q;
    assign de_out     = de_q;

endmodule

// File: tb/tb_mda_char_serializer.sv
// Bench for mda_char_serializer: directed cells through a behavioural font ROM, dot-by-dot scoreboard.
module tb_mda_char_serializer;

    typedef struct packed {
        logic       pix;
        logic       pix_nl;
        logic [7:0] att;
        logic [4:0] row;
        logic       cur;
        logic       de;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  char_byte = '0;
    logic [7:0]  att_in = '0;
    logic [4:0]  row_in = '0;
    logic        cursor_in = 1'b0;
    logic        de_in = 1'b0;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic        cell_start, pix_out, cursor_out, de_out;
    logic [7:0]  att_out;
    logic [4:0]  row_out;

    logic [11:0] nl_rom_addr;
    logic        nl_cs, nl_pix, nl_cur, nl_de;
    logic [7:0]  nl_att;
    logic [4:0]  nl_row;

    int   n_checks = 0;
    int   n_err = 0;
    ent_t exp_q[$];
    ent_t last_e = '0;

    always #5 clk = ~clk;

    mda_char_serializer dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .line_start(line_start),
        .char_byte(char_byte), .att_in(att_in), .row_in(row_in), .cursor_in(cursor_in),
        .de_in(de_in), .rom_addr(rom_addr), .rom_data(rom_data), .cell_start(cell_start),
        .pix_out(pix_out), .att_out(att_out), .row_out(row_out), .cursor_out(cursor_out),
        .de_out(de_out)
    );

    mda_char_serializer #(.DOTS(9), .LINE_GFX(1'b0), .ROW_BITS(4)) dut_nl (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .line_start(line_start),
        .char_byte(char_byte), .att_in(att_in), .row_in(row_in), .cursor_in(cursor_in),
        .de_in(de_in), .rom_addr(nl_rom_addr), .rom_data(rom_data), .cell_start(nl_cs),
        .pix_out(nl_pix), .att_out(nl_att), .row_out(nl_row), .cursor_out(nl_cur),
        .de_out(nl_de)
    );

    function automatic logic [7:0] font(input logic [7:0] c, input logic [3:0] r);
        if (c == 8'hC4) return 8'hFF;
        if (c == 8'hB3) return 8'h18;
        return c ^ {r, r};
    endfunction

    // synchronous font ROM, one clk read latency
    always @(posedge clk) rom_data <= font(rom_addr[11:4], rom_addr[3:0]);

    task automatic push_zero_cell();
        for (int k = 0; k < 9; k++) exp_q.push_back('0);
    endtask

    task automatic step(input logic ce, input logic ls, input logic dot0);
        ent_t        e, obs, cap[9];
        logic        cs, ncs;
        logic [7:0]  g;
        logic [11:0] exp_addr;
        @(negedge clk);
        pix_ce = ce;
        line_start = ls;
        #1;
        cs  = cell_start;
        ncs = nl_cs;
        n_checks++;
        assert (cs === dot0) else begin
            n_err++;
            $error("FAIL cell_start observed=%b expected=%b", cs, dot0);
        end
        n_checks++;
        assert (ncs === dot0) else begin
            n_err++;
            $error("FAIL nl_cell_start observed=%b expected=%b", ncs, dot0);
        end
        g = font(char_byte, row_in[3:0]);
        exp_addr = {char_byte, row_in[3:0]};
        for (int k = 0; k < 9; k++) begin
            cap[k].pix    = (k < 8) ? g[7-k] : ((char_byte[7:5] == 3'b110) ? g[0] : 1'b0);
            cap[k].pix_nl = (k < 8) ? g[7-k] : 1'b0;
            cap[k].att    = att_in;
            cap[k].row    = row_in;
            cap[k].cur    = cursor_in;
            cap[k].de     = de_in;
        end
        @(posedge clk);
        #1;
        obs = '{pix_out, nl_pix, att_out, row_out, cursor_out, de_out};
        if (ce) begin
            // an early cell start discards the undisplayed dots of the aborted cell
            if (dot0) while (exp_q.size() > 9) void'(exp_q.pop_front());
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL dot_underflow observed=%h expected=<none>", obs);
            end else begin
                e = exp_q.pop_front();
                last_e = e;
                assert (obs === e) else begin
                    n_err++;
                    $error("FAIL dot observed=%h expected=%h", obs, e);
                end
                n_checks++;
                assert ({nl_att, nl_row, nl_cur, nl_de} === {e.att, e.row, e.cur, e.de}) else begin
                    n_err++;
                    $error("FAIL nl_side observed=%h expected=%h",
                           {nl_att, nl_row, nl_cur, nl_de}, {e.att, e.row, e.cur, e.de});
                end
            end
            if (dot0) begin
                for (int k = 0; k < 9; k++) exp_q.push_back(cap[k]);
                n_checks++;
                assert (rom_addr === exp_addr && nl_rom_addr === exp_addr) else begin
                    n_err++;
                    $error("FAIL rom_addr observed=%h/%h expected=%h", rom_addr, nl_rom_addr, exp_addr);
                end
            end
        end else begin
            n_checks++;
            assert (obs === last_e) else begin
                n_err++;
                $error("FAIL hold observed=%h expected=%h", obs, last_e);
            end
        end
    endtask

    task automatic run_cell(input logic [7:0] c, input logic [7:0] a, input logic [4:0] r,
                            input logic cu, input logic d, input logic ls,
                            input int ndots, input int gap);
        char_byte = c;
        att_in    = a;
        row_in    = r;
        cursor_in = cu;
        de_in     = d;
        for (int i = 0; i < ndots; i++) begin
            step(1'b1, (i == 0) ? ls : 1'b0, i == 0);
            for (int j = 0; j < gap; j++) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        assert ({pix_out, att_out, row_out, cursor_out, de_out, rom_addr, cell_start} === '0) else begin
            n_err++;
            $error("FAIL reset_state observed=%h expected=0",
                   {pix_out, att_out, row_out, cursor_out, de_out, rom_addr, cell_start});
        end
        @(negedge clk);
        reset_n = 1'b1;
        push_zero_cell();

        // basic cell, then line-graphics and ordinary glyphs
        run_cell(8'h41, 8'h07, 5'd3, 1'b0, 1'b1, 1'b0, 9, 0);
        run_cell(8'hC4, 8'h0F, 5'd5, 1'b0, 1'b1, 1'b0, 9, 0);
        run_cell(8'hB3, 8'h70, 5'd2, 1'b0, 1'b1, 1'b0, 9, 0);
        run_cell(8'hD9, 8'h07, 5'd18, 1'b0, 1'b1, 1'b0, 9, 0);
        // cursor on, display disabled for one cell
        run_cell(8'h20, 8'h0F, 5'd0, 1'b1, 1'b0, 1'b0, 9, 0);
        run_cell(8'h41, 8'h07, 5'd3, 1'b0, 1'b1, 1'b0, 9, 0);

        // half-rate dot clock enable
        run_cell(8'h5A, 8'h01, 5'd7, 1'b0, 1'b1, 1'b0, 9, 1);
        run_cell(8'hC4, 8'h02, 5'd9, 1'b0, 1'b1, 1'b0, 9, 1);
        run_cell(8'h66, 8'h03, 5'd1, 1'b0, 1'b1, 1'b0, 9, 1);

        // line_start at dot 4 aborts the current cell
        run_cell(8'h33, 8'h07, 5'd1, 1'b0, 1'b1, 1'b0, 4, 0);
        run_cell(8'h44, 8'h09, 5'd4, 1'b0, 1'b1, 1'b1, 9, 0);
        run_cell(8'h20, 8'h07, 5'd0, 1'b0, 1'b1, 1'b0, 9, 0);

        // asynchronous reset mid-cell
        run_cell(8'h77, 8'h07, 5'd6, 1'b0, 1'b1, 1'b0, 3, 0);
        pix_ce = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        assert ({pix_out, att_out, row_out, cursor_out, de_out, rom_addr} === '0) else begin
            n_err++;
            $error("FAIL async_reset observed=%h expected=0",
                   {pix_out, att_out, row_out, cursor_out, de_out, rom_addr});
        end
        @(posedge clk);
        @(posedge clk);
        #4 reset_n = 1'b1;
        exp_q.delete();
        last_e = '0;
        push_zero_cell();
        run_cell(8'h55, 8'h07, 5'd2, 1'b0, 1'b1, 1'b0, 9, 0);
        run_cell(8'hCF, 8'h70, 5'd11, 1'b1, 1'b1, 1'b0, 9, 0);
        run_cell(8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 9, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mda_char_serializer.md
Name: mda_char_serializer

Overview:
- Text-mode dot serializer directly upstream of the MDA attribute stage.
- Once per character cell it captures the character code, attribute byte, scan-row, cursor and display-enable fetched from VRAM, and addresses the synchronous font ROM.
- It shifts the returned glyph row out one dot per pixel clock-enable, with MDA 9th-column replication.
- Attribute, row, cursor and enable are delayed so they arrive aligned with their dots at the attribute stage's att_byte/row_addr/cursor/display_enable/pix_in inputs.

Parameters:
- DOTS, 9, dots per character cell; legal values 8 or 9.
- LINE_GFX, 1, when 1 and DOTS=9, codes 0xC0-0xDF replicate dot 7 into dot 8.
- ROW_BITS, 4, scan-row bits used in the font address.

Ports:
- clk  in  1  pixel-domain clock
- reset_n  in  1  asynchronous active-low reset
- pix_ce  in  1  dot clock enable; all state advances only when high
- line_start  in  1  qualified by pix_ce; forces the current dot to be dot 0 of a new cell
- char_byte  in  8  character code from VRAM, valid at dot 0
- att_in  in  8  attribute byte, valid at dot 0
- row_in  in  5  current scan row, valid at dot 0
- cursor_in  in  1  cursor active for this cell, valid at dot 0
- de_in  in  1  display enable for this cell, valid at dot 0
- rom_addr  out  8+ROW_BITS  font ROM address, {char, row_in[ROW_BITS-1:0]}, registered
- rom_data  in  8  font ROM output, bit 7 = leftmost dot; one-clk read latency
- cell_start  out  1  high for the clk in which dot 0 is captured (pix_ce & dot==0); VRAM fetch handshake
- pix_out  out  1  serialized dot
- att_out  out  8  attribute aligned to pix_out
- row_out  out  5  row aligned to pix_out
- cursor_out  out  1  cursor aligned to pix_out
- de_out  out  1  display enable aligned to pix_out

Behaviour:
- Reset (reset_n low, asynchronous):
  - dot counter = 0; shifter, stage-1 and output registers = 0.
  - rom_addr = 0; all outputs = 0.
  - Dot 0 is the first pix_ce after release.
- Dot counter:
  - Counts 0..DOTS-1 on pix_ce and wraps to 0.
  - line_start & pix_ce makes this ce dot 0 (the counter goes to 1 next); this overrides any count.
  - Mid-cell line_start aborts the remaining dots of the current cell. The shifter reloads immediately with whatever font data is in stage 2.
- Stage 1, at dot 0 (pix_ce & dot==0):
  - Register char_byte, att_in, row_in, cursor_in, de_in.
  - rom_addr <= {char_byte, row_in[ROW_BITS-1:0]}.
  - Rows >= 2^ROW_BITS alias (the ROM is responsible for blank rows).
- ROM: rom_data is valid from the clk after the rom_addr update. It is held until the next dot-0 update plus one clk. pix_ce may be high every clk.
- Stage 2 / load, at the same dot-0 ce as the next capture:
  - Shifter <= rom_data (the previous cell's glyph row).
  - att_out, row_out, cursor_out, de_out <= stage-1 values captured one cell earlier.
  - ninth <= LINE_GFX & DOTS==9 & prev_char[7:5]==3'b110 ? rom_data[0] : 0.
- Shift:
  - pix_out = shifter MSB, registered.
  - Dots 0-7 output bits 7..0.
  - Dot 8 (DOTS=9) outputs ninth.
  - Shifting occurs on pix_ce only.
  - With pix_ce low, every output holds.
- Latency: a cell captured at dot 0 of cell k appears on pix_out/att_out/... from dot 0 of cell k+1, i.e. DOTS pix_ce later. Side-band outputs change only at dot 0.
- de_in low still shifts glyph data; masking is the downstream stage's job.
- The first cell after reset or line_start outputs the stale/zero pipeline contents for one cell.

Test Plan:
- Reset then pix_ce every clk, char 0x41, att 0x07, row 3, de 1 -> rom_addr=0x413 one clk after dot 0; the next cell shows pix_out = rom_data bits 7..0, then 0 at dot 8, with att_out=0x07 and row_out=3.
- char 0xC4 with rom_data 0xFF, DOTS=9 -> dots 0-8 all 1. char 0xB3 with rom_data 0x18 -> dot 8 = 0. LINE_GFX=0 with 0xC4 -> dot 8 = 0.
- pix_ce toggled every 2nd clk -> identical dot sequence at half rate; cell_start asserted once per 9 ce; outputs stable while ce is low.
- line_start asserted at dot 4 -> counter restarts; cell_start the same clk; the shifter reloads at that ce; no dot 5-8 of the aborted cell appears.
- cursor_in=1, de_in=0 for one cell between normal cells -> cursor_out=1 and de_out=0 exactly for the following cell's 9 dots, with att_out unchanged from the captured value.
- reset_n pulsed low mid-cell, asynchronously between edges -> all outputs 0 immediately; after release, rom_addr updates at the first pix_ce.
